// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: FSM encoding, divide
// latency default and the load-use detection rule.
package hazard_unit_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DIV = 1'b1
  } hz_state_e;

  localparam int DIV_CYCLES_DEF = 8;

  // Load in EX writes a register the ID instruction reads; r0 never hazards.
  function automatic logic load_use_f(
    input logic       memread,
    input logic [4:0] rt_ex,
    input logic [4:0] rs_id,
    input logic [4:0] rt_id,
    input logic       uses_rt
  );
    return memread && (rt_ex != 5'd0) &&
           ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush and multi-cycle
// divide freeze, plus a saturating count of stalled-PC cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rt_id,
  input  logic [4:0]  rt_ex,
  input  logic        memread_ex,
  input  logic        div_start_ex,
  input  logic        branch_taken_ex,
  input  logic        stat_clr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        busy,
  output logic [15:0] hazard_cnt
);

  // The start cycle freezes the front end itself, so DIV only has to cover
  // the remaining DIV_CYCLES-2 frozen cycles.
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

  hz_state_e   state_q;
  logic [7:0]  div_cnt_q;
  logic [15:0] hazard_cnt_q, hazard_cnt_d;
  logic        load_use;

  assign load_use = load_use_f(memread_ex, rt_ex, rs_id, rt_id, uses_rt_id);

  // Stall/flush controls decoded from state and the current ID/EX fields.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (state_q == ST_DIV) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (div_start_ex) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // RUN/DIV sequencing; DIV exits on the cycle its counter reaches 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      div_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (div_start_ex && !branch_taken_ex && (DIV_LOAD != 8'd0)) begin
            state_q   <= ST_DIV;
            div_cnt_q <= DIV_LOAD;
          end
        end
        ST_DIV: begin
          if (div_cnt_q <= 8'd1) begin
            state_q   <= ST_RUN;
            div_cnt_q <= 8'd0;
          end else begin
            div_cnt_q <= div_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          div_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  // Stall statistics: clear wins, otherwise count PC-hold cycles up to max.
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (stat_clr)
      hazard_cnt_d = 16'd0;
    else if (!pc_write && (hazard_cnt_q != 16'hFFFF))
      hazard_cnt_d = hazard_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hazard_cnt_q <= 16'd0;
    else        hazard_cnt_q <= hazard_cnt_d;
  end

  assign busy       = (state_q == ST_DIV);
  assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized bench for hazard_unit against a stall-budget reference model.
module tb_hazard_unit;

  localparam int DIV_CYCLES = 8;

  logic        clk, rst_n;
  logic [4:0]  rs_id, rt_id, rt_ex;
  logic        uses_rt_id, memread_ex, div_start_ex, branch_taken_ex, stat_clr;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic        exmem_bubble, busy;
  logic [15:0] hazard_cnt;

  hazard_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rt_ex(rt_ex), .memread_ex(memread_ex), .div_start_ex(div_start_ex),
    .branch_taken_ex(branch_taken_ex), .stat_clr(stat_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .busy(busy), .hazard_cnt(hazard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: number of frozen cycles still owed after the current one, and
  // the stall count as a plain integer.
  int m_rem = 0;
  int m_hc  = 0;
  bit obs_pc, obs_busy;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rs_id = 5'd0; rt_id = 5'd0; rt_ex = 5'd0; uses_rt_id = 1'b0;
    memread_ex = 1'b0; div_start_ex = 1'b0; branch_taken_ex = 1'b0;
    stat_clr = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances
  // one cycle and returns at the next negedge.
  task automatic step(input bit do_chk);
    bit lu, frozen, e_pc, e_ifw, e_fl, e_idw, e_idb, e_exb;
    #1;
    lu = memread_ex && rt_ex != 0 &&
         (rt_ex == rs_id || (uses_rt_id && rt_ex == rt_id));
    frozen = (m_rem > 0) || (!branch_taken_ex && div_start_ex);
    e_pc = 1; e_ifw = 1; e_fl = 0; e_idw = 1; e_idb = 0; e_exb = 0;
    if (frozen) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exb = 1;
    end else if (branch_taken_ex) begin
      e_fl = 1; e_idb = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_idb = 1;
    end
    obs_pc = pc_write; obs_busy = busy;
    if (do_chk) begin
      chk("pc_write",     pc_write,     e_pc);
      chk("ifid_write",   ifid_write,   e_ifw);
      chk("ifid_flush",   ifid_flush,   e_fl);
      chk("idex_write",   idex_write,   e_idw);
      chk("idex_bubble",  idex_bubble,  e_idb);
      chk("exmem_bubble", exmem_bubble, e_exb);
      chk("busy",         busy,         (m_rem > 0) ? 1 : 0);
      chk("hazard_cnt",   hazard_cnt,   m_hc);
    end
    @(posedge clk);
    if (rst_n) begin
      if (stat_clr) m_hc = 0;
      else if (!e_pc && m_hc < 65535) m_hc++;
      if (m_rem > 0) m_rem--;
      else if (div_start_ex && !branch_taken_ex) m_rem = DIV_CYCLES - 2;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_rem = 0; m_hc = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pc_low, busy_hi;
    set_idle();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; m_rem = 0; m_hc = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hc", hazard_cnt, 0);
    chk("rst_pc", pc_write, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs.
    memread_ex = 1; rt_ex = 5'd6; rs_id = 5'd6;
    step(1);
    chk("lu_hc", hazard_cnt, 1);
    set_idle();
    step(1);

    // No false stalls: r0, and rt match without uses_rt.
    memread_ex = 1; rt_ex = 0; rs_id = 0;
    step(1);
    memread_ex = 1; rt_ex = 5'd9; rt_id = 5'd9; rs_id = 5'd3; uses_rt_id = 0;
    step(1);
    // Branch beats load-use.
    memread_ex = 1; rt_ex = 5'd4; rs_id = 5'd4; branch_taken_ex = 1;
    step(1);
    set_idle();

    // Divide latency with a cleared counter.
    stat_clr = 1;
    step(1);
    stat_clr = 0;
    div_start_ex = 1;
    pc_low = 0; busy_hi = 0;
    step(1);
    div_start_ex = 0;
    pc_low += obs_pc ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      pc_low  += obs_pc ? 0 : 1;
      busy_hi += obs_busy ? 1 : 0;
    end
    chk("div_pc_low", pc_low, DIV_CYCLES - 1);
    chk("div_busy", busy_hi, DIV_CYCLES - 2);
    chk("div_hc", hazard_cnt, DIV_CYCLES - 1);

    // Reset three cycles into DIV.
    div_start_ex = 1;
    step(1);
    div_start_ex = 0;
    for (int i = 0; i < 3; i++) step(1);
    rst_n = 1'b0; m_rem = 0; m_hc = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hc", hazard_cnt, 0);
    chk("mid_rst_pc", pc_write, 1);
    @(negedge clk);
    step(1);
    rst_n = 1'b1;
    step(1);
    step(1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rs_id           = 5'($urandom_range(0, 7));
      rt_id           = 5'($urandom_range(0, 7));
      rt_ex           = 5'($urandom_range(0, 7));
      uses_rt_id      = 1'($urandom_range(0, 1));
      memread_ex      = 1'($urandom_range(0, 1));
      div_start_ex    = ($urandom_range(0, 15) == 0);
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      stat_clr        = ($urandom_range(0, 63) == 0);
      step(1);
    end
    set_idle();
    for (int i = 0; i < DIV_CYCLES; i++) step(1);

    // Saturation and clear under an active stall.
    stat_clr = 1;
    step(1);
    stat_clr = 0;
    memread_ex = 1; rt_ex = 5'd7; rs_id = 5'd7;
    for (int i = 0; i < 65540; i++) step(0);
    #1;
    chk("sat_hc", hazard_cnt, 16'hFFFF);
    chk("sat_pc", pc_write, 0);
    stat_clr = 1;
    step(1);
    stat_clr = 0;
    #1;
    chk("clr_hc", hazard_cnt, 0);
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
